// File: rtl/counter_cmd_sched.sv
// UART command decoder and TX scheduler for the 10 Hz up/down counter.
// Echoes every received byte and sends count reports as 4 ASCII digits (+ CR LF).
module counter_cmd_sched #(
    parameter logic [7:0] CMD_RUN   = 8'h52,
    parameter logic [7:0] CMD_STOP  = 8'h53,
    parameter logic [7:0] CMD_CLEAR = 8'h43,
    parameter logic [7:0] CMD_MODE  = 8'h4D,
    parameter logic [7:0] CMD_QUERY = 8'h51,
    parameter bit         LINE_END  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic        tx_busy,
    input  logic        tx_done,
    input  logic [13:0] count,
    output logic        en,
    output logic        mode,
    output logic        clear,
    output logic        start_trigger,
    output logic [7:0]  tx_data,
    output logic        echo_ovf
);

    localparam logic [2:0] REP_LEN = LINE_END ? 3'd6 : 3'd4;

    typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;

    tx_state_t   state, state_nxt;
    logic        echo_full;
    logic [7:0]  echo_byte;
    logic        rep_active;
    logic [2:0]  rep_idx;
    logic        cur_is_rep;
    logic [13:0] snapshot;
    logic        rep_pending;
    logic [7:0]  rep_byte;
    logic [3:0]  d3, d2, d1, d0;
    logic        launch, launch_echo;

    assign rep_pending = rep_active && (rep_idx < REP_LEN);

    always_comb begin
        d3 = 4'(snapshot / 14'd1000);
        d2 = 4'((snapshot / 14'd100) % 14'd10);
        d1 = 4'((snapshot / 14'd10) % 14'd10);
        d0 = 4'(snapshot % 14'd10);
        case (rep_idx)
            3'd0:    rep_byte = 8'h30 + {4'h0, d3};
            3'd1:    rep_byte = 8'h30 + {4'h0, d2};
            3'd2:    rep_byte = 8'h30 + {4'h0, d1};
            3'd3:    rep_byte = 8'h30 + {4'h0, d0};
            3'd4:    rep_byte = 8'h0D;
            default: rep_byte = 8'h0A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= TX_IDLE;
        else      state <= state_nxt;
    end

    // A pending echo always wins over the next report byte.
    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        launch_echo = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!tx_busy && (echo_full || rep_pending)) begin
                    launch      = 1'b1;
                    launch_echo = echo_full;
                    state_nxt   = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (tx_done) state_nxt = TX_IDLE;
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en            <= 1'b0;
            mode          <= 1'b0;
            clear         <= 1'b0;
            start_trigger <= 1'b0;
            tx_data       <= '0;
            echo_ovf      <= 1'b0;
            echo_full     <= 1'b0;
            echo_byte     <= '0;
            rep_active    <= 1'b0;
            rep_idx       <= '0;
            cur_is_rep    <= 1'b0;
            snapshot      <= '0;
        end else begin
            clear         <= 1'b0;
            start_trigger <= launch;

            if (launch) begin
                tx_data    <= launch_echo ? echo_byte : rep_byte;
                cur_is_rep <= !launch_echo;
                if (!launch_echo) rep_idx <= rep_idx + 3'd1;
            end

            if (state == TX_WAIT && tx_done && cur_is_rep && rep_idx == REP_LEN)
                rep_active <= 1'b0;

            // A launch in the same cycle frees the buffer, so that is not an overflow.
            if (rx_done) begin
                echo_byte <= rx_data;
                echo_full <= 1'b1;
                if (echo_full && !launch_echo) echo_ovf <= 1'b1;
            end else if (launch_echo) begin
                echo_full <= 1'b0;
            end

            if (rx_done) begin
                case (rx_data)
                    CMD_RUN:   en <= 1'b1;
                    CMD_STOP:  en <= 1'b0;
                    CMD_MODE:  mode <= ~mode;
                    CMD_CLEAR: begin
                        clear <= 1'b1;
                        en    <= 1'b0;
                    end
                    CMD_QUERY: begin
                        if (!rep_active) begin
                            rep_active <= 1'b1;
                            rep_idx    <= '0;
                            snapshot   <= count;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
